// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for the rv32i five-stage pipeline.
// Combinational forward/stall/flush decode plus registered cycle class, counters and timeout.
module hazard_ctrl #(
    parameter int ADW      = 5,
    parameter int FWD_EN   = 1,
    parameter int CNTW     = 16,
    parameter int WAIT_MAX = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [ADW-1:0]  Rs1D,
    input  logic [ADW-1:0]  Rs2D,
    input  logic [ADW-1:0]  Rs1E,
    input  logic [ADW-1:0]  Rs2E,
    input  logic [ADW-1:0]  RdE,
    input  logic [ADW-1:0]  RdM,
    input  logic [ADW-1:0]  RdW,
    input  logic            regwriteE,
    input  logic            regwriteM,
    input  logic            regwriteW,
    input  logic            resultsrcE,
    input  logic            PCSrcE,
    input  logic            mem_ready,
    input  logic            cnt_clr,
    output logic [1:0]      forwardAE,
    output logic [1:0]      forwardBE,
    output logic            stallF,
    output logic            stallD,
    output logic            stallE,
    output logic            stallM,
    output logic            flushD,
    output logic            flushE,
    output logic [1:0]      state,
    output logic [CNTW-1:0] stall_cnt,
    output logic [CNTW-1:0] flush_cnt,
    output logic            err_timeout
);

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        HAZ   = 2'b01,
        WAIT  = 2'b10,
        FLUSH = 2'b11
    } cycleClass_e;

    localparam int WCW = $clog2(WAIT_MAX + 1);
    localparam logic [WCW-1:0] WMAX   = WCW'(WAIT_MAX);
    localparam logic [WCW-1:0] WMAXM1 = WCW'(WAIT_MAX - 1);

    // x0 is hardwired zero, so it never creates a dependency
    function automatic logic hit(
        input logic           en,
        input logic [ADW-1:0] rd,
        input logic [ADW-1:0] rs
    );
        return en && (rd != '0) && (rd == rs);
    endfunction

    function automatic logic [1:0] fwdSel(input logic [ADW-1:0] rs);
        if (hit(regwriteM, RdM, rs)) return 2'b10;
        else if (hit(regwriteW, RdW, rs)) return 2'b01;
        else return 2'b00;
    endfunction

    logic        haz;
    cycleClass_e cls;
    cycleClass_e stateQ;
    logic [WCW-1:0] waitCnt;
    logic [WCW-1:0] waitNext;
    logic        timeoutHit;

    generate
        if (FWD_EN != 0) begin : gFwd
            assign forwardAE = fwdSel(Rs1E);
            assign forwardBE = fwdSel(Rs2E);
            assign haz = resultsrcE
                      && (hit(1'b1, RdE, Rs1D) || hit(1'b1, RdE, Rs2D));
        end else begin : gNoFwd
            assign forwardAE = 2'b00;
            assign forwardBE = 2'b00;
            assign haz = hit(regwriteE, RdE, Rs1D)
                      || hit(regwriteE, RdE, Rs2D)
                      || hit(regwriteM, RdM, Rs1D)
                      || hit(regwriteM, RdM, Rs2D)
                      || hit(regwriteW, RdW, Rs1D)
                      || hit(regwriteW, RdW, Rs2D);
        end
    endgenerate

    // Terms are made mutually exclusive to encode the priority order
    always_comb begin
        cls = RUN;
        unique case (1'b1)
            !mem_ready:                     cls = WAIT;
            mem_ready && PCSrcE:            cls = FLUSH;
            mem_ready && !PCSrcE && haz:    cls = HAZ;
            default:                        cls = RUN;
        endcase
    end

    assign stallF = (cls == WAIT) || (cls == HAZ);
    assign stallD = stallF;
    assign stallE = (cls == WAIT);
    assign stallM = stallE;
    assign flushD = (cls == FLUSH);
    assign flushE = (cls == FLUSH) || (cls == HAZ);

    assign state = stateQ;

    assign waitNext = mem_ready          ? '0 :
                      (waitCnt == WMAX)  ? waitCnt :
                                           waitCnt + 1'b1;

    // Fires only on the transition into the WAIT_MAX-th wait cycle
    assign timeoutHit = !mem_ready && (waitCnt == WMAXM1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ      <= RUN;
            waitCnt     <= '0;
            stall_cnt   <= '0;
            flush_cnt   <= '0;
            err_timeout <= 1'b0;
        end else begin
            stateQ  <= cls;
            waitCnt <= waitNext;
            if (cnt_clr) begin
                stall_cnt   <= '0;
                flush_cnt   <= '0;
                err_timeout <= 1'b0;
            end else begin
                if (stallD && (stall_cnt != '1))
                    stall_cnt <= stall_cnt + 1'b1;
                if (flushE && (flush_cnt != '1))
                    flush_cnt <= flush_cnt + 1'b1;
                if (timeoutHit)
                    err_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomised bench for hazard_ctrl: forwarding and no-forwarding instances
// checked each cycle against a rule-level reference model.
module tb_hazard_ctrl;

    localparam int ADW  = 5;
    localparam int CNTW = 4;
    localparam int WMAX = 8;
    localparam int CMAX = (1 << CNTW) - 1;

    logic clk = 1'b0;
    logic rst_n;
    logic [ADW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic regwriteE, regwriteM, regwriteW;
    logic resultsrcE, PCSrcE, mem_ready, cnt_clr;

    logic [1:0] fA [2];
    logic [1:0] fB [2];
    logic [1:0] st [2];
    logic sF [2];
    logic sD [2];
    logic sE [2];
    logic sM [2];
    logic fD [2];
    logic fE [2];
    logic err [2];
    logic [CNTW-1:0] sc [2];
    logic [CNTW-1:0] fc [2];

    int nChecks = 0;
    int nPass   = 0;

    int mState [2];
    int mStall [2];
    int mFlush [2];
    int mWait  [2];
    bit mErr   [2];

    always #10 clk = ~clk;

    hazard_ctrl #(.ADW(ADW), .FWD_EN(1), .CNTW(CNTW), .WAIT_MAX(WMAX)) dutFwd (
        .clk(clk), .rst_n(rst_n),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .resultsrcE(resultsrcE), .PCSrcE(PCSrcE),
        .mem_ready(mem_ready), .cnt_clr(cnt_clr),
        .forwardAE(fA[0]), .forwardBE(fB[0]),
        .stallF(sF[0]), .stallD(sD[0]), .stallE(sE[0]), .stallM(sM[0]),
        .flushD(fD[0]), .flushE(fE[0]), .state(st[0]),
        .stall_cnt(sc[0]), .flush_cnt(fc[0]), .err_timeout(err[0])
    );

    hazard_ctrl #(.ADW(ADW), .FWD_EN(0), .CNTW(CNTW), .WAIT_MAX(WMAX)) dutNoFwd (
        .clk(clk), .rst_n(rst_n),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .resultsrcE(resultsrcE), .PCSrcE(PCSrcE),
        .mem_ready(mem_ready), .cnt_clr(cnt_clr),
        .forwardAE(fA[1]), .forwardBE(fB[1]),
        .stallF(sF[1]), .stallD(sD[1]), .stallE(sE[1]), .stallM(sM[1]),
        .flushD(fD[1]), .flushE(fE[1]), .state(st[1]),
        .stall_cnt(sc[1]), .flush_cnt(fc[1]), .err_timeout(err[1])
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    endtask

    function automatic bit match(bit en, int rd, int rs);
        return en && (rd != 0) && (rd == rs);
    endfunction

    function automatic int fwdOf(int rs);
        if (match(regwriteM, RdM, rs)) return 2;
        if (match(regwriteW, RdW, rs)) return 1;
        return 0;
    endfunction

    function automatic bit hazOf(bit fwd);
        if (fwd)
            return resultsrcE && (match(1, RdE, Rs1D) || match(1, RdE, Rs2D));
        return match(regwriteE, RdE, Rs1D) || match(regwriteE, RdE, Rs2D)
            || match(regwriteM, RdM, Rs1D) || match(regwriteM, RdM, Rs2D)
            || match(regwriteW, RdW, Rs1D) || match(regwriteW, RdW, Rs2D);
    endfunction

    // 0 RUN, 1 HAZ, 2 WAIT, 3 FLUSH
    function automatic int classOf(bit fwd);
        if (!mem_ready) return 2;
        if (PCSrcE) return 3;
        if (hazOf(fwd)) return 1;
        return 0;
    endfunction

    task automatic checkComb(input int k);
        int c;
        bit fwd;
        fwd = (k == 0);
        c = classOf(fwd);
        check($sformatf("fwdA%0d", k), fA[k], fwd ? fwdOf(Rs1E) : 0);
        check($sformatf("fwdB%0d", k), fB[k], fwd ? fwdOf(Rs2E) : 0);
        check($sformatf("stallF%0d", k), sF[k], (c == 1 || c == 2));
        check($sformatf("stallD%0d", k), sD[k], (c == 1 || c == 2));
        check($sformatf("stallE%0d", k), sE[k], (c == 2));
        check($sformatf("stallM%0d", k), sM[k], (c == 2));
        check($sformatf("flushD%0d", k), fD[k], (c == 3));
        check($sformatf("flushE%0d", k), fE[k], (c == 1 || c == 3));
    endtask

    task automatic checkRegs(input int k);
        check($sformatf("state%0d", k), st[k], mState[k]);
        check($sformatf("stallCnt%0d", k), sc[k], mStall[k]);
        check($sformatf("flushCnt%0d", k), fc[k], mFlush[k]);
        check($sformatf("errTo%0d", k), err[k], mErr[k]);
    endtask

    task automatic modelEdge(input int k);
        int c;
        c = classOf(k == 0);
        mState[k] = c;
        if (cnt_clr) begin
            mStall[k] = 0;
            mFlush[k] = 0;
            mErr[k]   = 0;
        end else begin
            if (c == 1 || c == 2)
                mStall[k] = (mStall[k] < CMAX) ? mStall[k] + 1 : CMAX;
            if (c == 1 || c == 3)
                mFlush[k] = (mFlush[k] < CMAX) ? mFlush[k] + 1 : CMAX;
            if (!mem_ready && (mWait[k] + 1 == WMAX))
                mErr[k] = 1;
        end
        if (mem_ready) mWait[k] = 0;
        else mWait[k] = (mWait[k] < WMAX) ? mWait[k] + 1 : WMAX;
    endtask

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            mState[k] = 0;
            mStall[k] = 0;
            mFlush[k] = 0;
            mWait[k]  = 0;
            mErr[k]   = 0;
        end
    endtask

    // Called with clk low; checks comb, crosses one rising edge, checks regs
    task automatic step();
        #1;
        for (int k = 0; k < 2; k++) checkComb(k);
        for (int k = 0; k < 2; k++) modelEdge(k);
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) checkRegs(k);
        @(negedge clk);
    endtask

    task automatic rstPulse();
        rst_n = 1'b0;
        #1;
        modelReset();
        for (int k = 0; k < 2; k++) checkRegs(k);
        check("rstStallCnt", sc[0], 0);
        check("rstState", st[0], 0);
        rst_n = 1'b1;
    endtask

    task automatic zeroIn();
        Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0;
        RdE = '0; RdM = '0; RdW = '0;
        regwriteE = 0; regwriteM = 0; regwriteW = 0;
        resultsrcE = 0; PCSrcE = 0; mem_ready = 1; cnt_clr = 0;
    endtask

    task automatic loadUse();
        zeroIn();
        resultsrcE = 1; RdE = 5'd7; Rs2D = 5'd7;
    endtask

    int burst;

    initial begin
        zeroIn();
        rst_n = 1'b0;
        modelReset();
        #1;
        for (int k = 0; k < 2; k++) checkRegs(k);
        @(negedge clk);
        rst_n = 1'b1;

        // forwarding priority
        Rs1E = 5'd5; RdM = 5'd5; RdW = 5'd5; regwriteM = 1; regwriteW = 1;
        #1 check("fwdMem", fA[0], 2'b10);
        regwriteM = 0;
        #1 check("fwdWb", fA[0], 2'b01);
        Rs1E = '0; RdM = '0; RdW = '0;
        #1 check("fwdX0", fA[0], 2'b00);

        // load-use
        loadUse();
        #1;
        check("luStallF", sF[0], 1);
        check("luFlushE", fE[0], 1);
        check("luStallE", sE[0], 0);
        step();
        check("luState", st[0], 2'b01);
        check("luStallCnt", sc[0], 1);
        check("luFlushCnt", fc[0], 1);

        // branch beats hazard
        PCSrcE = 1;
        #1;
        check("brFlushD", fD[0], 1);
        check("brStallD", sD[0], 0);
        step();
        check("brState", st[0], 2'b11);
        check("brStallCnt", sc[0], 1);

        // memory wait and timeout
        mem_ready = 0;
        #1;
        check("wtStallM", sM[0], 1);
        check("wtFlushE", fE[0], 0);
        for (int i = 1; i <= WMAX; i++) begin
            step();
            if (i == WMAX - 1) check("toEarly", err[0], 0);
        end
        check("toSet", err[0], 1);
        zeroIn();
        step();
        check("toSticky", err[0], 1);
        cnt_clr = 1;
        step();
        check("toClr", err[0], 0);
        cnt_clr = 0;

        // no-forward mode
        zeroIn();
        regwriteW = 1; RdW = 5'd3; Rs1D = 5'd3; Rs1E = 5'd3;
        #1;
        check("nfStallD", sD[1], 1);
        check("nfFlushE", fE[1], 1);
        check("nfFwdA", fA[1], 2'b00);
        check("fwFwdA", fA[0], 2'b01);
        step();

        // reset in the middle of a wait run
        zeroIn();
        mem_ready = 0;
        for (int i = 0; i < 5; i++) step();
        rstPulse();
        for (int i = 0; i < 5; i++) step();
        check("rstWaitNoTo", err[0], 0);
        zeroIn();
        step();

        // saturation then async reset
        cnt_clr = 1;
        step();
        loadUse();
        for (int i = 0; i < 20; i++) step();
        check("satStall", sc[0], CMAX);
        rstPulse();
        step();

        // randomised traffic
        burst = 0;
        for (int n = 0; n < 1500; n++) begin
            Rs1D = ADW'($urandom_range(0, 3));
            Rs2D = ADW'($urandom_range(0, 3));
            Rs1E = ADW'($urandom_range(0, 3));
            Rs2E = ADW'($urandom_range(0, 3));
            RdE  = ADW'($urandom_range(0, 3));
            RdM  = ADW'($urandom_range(0, 3));
            RdW  = ADW'($urandom_range(0, 3));
            regwriteE  = 1'($urandom_range(0, 1));
            regwriteM  = 1'($urandom_range(0, 1));
            regwriteW  = 1'($urandom_range(0, 1));
            resultsrcE = 1'($urandom_range(0, 1));
            PCSrcE     = ($urandom_range(0, 3) == 0);
            cnt_clr    = ($urandom_range(0, 39) == 0);
            if (burst == 0 && $urandom_range(0, 19) == 0)
                burst = $urandom_range(1, 12);
            mem_ready = (burst == 0);
            if (burst > 0) burst--;
            if ($urandom_range(0, 299) == 0) rstPulse();
            step();
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised hazard and forwarding controller for the rv32i five-stage pipeline (fetch, decode, execute, memory, writeback). It generates the forwarding selects, per-stage stall and flush controls, and a registered pipeline-condition state. It also keeps saturating stall/flush performance counters and a memory-wait timeout flag. It sits beside the stage registers, reading register addresses and control bits from the decode, execute, memory and writeback stages.

## Interface
Parameters:
- ADW, 5, register address width
- FWD_EN, 1, 1 = forwarding enabled; 0 = no forwarding, resolve every RAW hazard by stalling
- CNTW, 16, performance counter width
- WAIT_MAX, 8, consecutive mem_ready-low cycles that raise err_timeout (≥1)

Ports:
- clk  in  1  clock; one clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- Rs1D, Rs2D  in  ADW  decode-stage source addresses
- Rs1E, Rs2E  in  ADW  execute-stage source addresses
- RdE, RdM, RdW  in  ADW  destination addresses in execute, memory and writeback
- regwriteE, regwriteM, regwriteW  in  1  destination write enables per stage
- resultsrcE  in  1  execute-stage instruction is a load
- PCSrcE  in  1  taken branch resolved in execute
- mem_ready  in  1  data memory can complete this cycle
- cnt_clr  in  1  synchronous clear of counters and err_timeout
- forwardAE, forwardBE  out  2  ALU operand select: 00 reg file, 10 memory-stage aluresult, 01 writeback result
- stallF, stallD, stallE, stallM  out  1  hold the fetch PC and the decode, execute and memory stage registers
- flushD, flushE  out  1  clear the decode and execute stage registers (bubble)
- state  out  2  registered cycle class: 00 RUN, 01 HAZ, 10 WAIT, 11 FLUSH
- stall_cnt, flush_cnt  out  CNTW  saturating counters
- err_timeout  out  1  sticky memory-wait timeout

## Operation
- Register x0 is never a hazard: any match term with an address of 0 is false.
- Forwarding (FWD_EN=1):
  - forwardAE=10 if regwriteM && RdM==Rs1E.
  - Otherwise forwardAE=01 if regwriteW && RdW==Rs1E.
  - Otherwise forwardAE=00.
  - forwardBE is identical, using Rs2E. The memory stage has priority over writeback.
- Forwarding (FWD_EN=0): forwardAE=forwardBE=00 constantly.
- Data hazard, haz:
  - FWD_EN=1: resultsrcE && RdE ∈ {Rs1D, Rs2D}.
  - FWD_EN=0: a Rs1D/Rs2D match against (regwriteE, RdE), (regwriteM, RdM) or (regwriteW, RdW).
- Priority, highest first:
  1. mem_ready=0 (WAIT): stallF=stallD=stallE=stallM=1; flushD=flushE=0. PCSrcE and haz are ignored; they are held stable by the stalled stages.
  2. PCSrcE=1 (FLUSH): flushD=flushE=1; all stalls 0. A branch overrides a coincident haz.
  3. haz=1 (HAZ): stallF=stallD=1; flushE=1; stallE=stallM=flushD=0.
  4. Otherwise RUN: all stall and flush outputs 0.
- The state register loads the class (RUN/HAZ/WAIT/FLUSH) of the current cycle at each edge. It therefore always shows the previous cycle's class.
- stall_cnt: +1 at each edge where stallD=1; saturates at 2^CNTW−1.
- flush_cnt: +1 at each edge where flushE=1; saturates at 2^CNTW−1.
- Timeout:
  - An internal wait counter, width $clog2(WAIT_MAX+1), increments on each mem_ready=0 cycle and clears on mem_ready=1.
  - err_timeout sets at the edge where the count reaches WAIT_MAX. It stays set until cnt_clr or reset.
  - The wait counter saturates at WAIT_MAX.
- cnt_clr=1 zeroes stall_cnt, flush_cnt and err_timeout at the edge, overriding any increment or set. It does not affect the wait counter or state.

## Timing
- forwardAE/BE and all stall/flush outputs are combinational, valid in the same cycle as their inputs, with zero latency.
- state, counters and err_timeout update on the rising edge; they lag the causing cycle by one cycle.
- Reset (rst_n=0) takes effect immediately, without waiting for clk:
  - state=00, stall_cnt=0, flush_cnt=0, err_timeout=0, wait counter=0.
  - Combinational outputs remain pure functions of the inputs during reset.
- Reset asserted mid-WAIT clears the wait counter. A wait run that straddles reset does not accumulate toward the timeout.
- Release of rst_n is synchronised externally. The first edge after release behaves as a normal cycle.
- A multi-cycle WAIT keeps all stalls asserted every cycle. Outputs resume the priority evaluation in the first cycle mem_ready=1.

## Test plan
- Forward priority: FWD_EN=1, Rs1E=5, RdM=5, RdW=5, regwriteM=regwriteW=1 → forwardAE=10. Then regwriteM=0 → forwardAE=01. Then Rs1E=0 with RdM=RdW=0 → forwardAE=00.
- Load-use: FWD_EN=1, resultsrcE=1, RdE=7, Rs2D=7 → stallF=stallD=flushE=1, stallE=0. Next edge: state=01, stall_cnt=1, flush_cnt=1.
- Branch over hazard: load-use condition plus PCSrcE=1 → flushD=flushE=1, stallF=0, stallD=0. Next edge: state=11, stall_cnt unchanged.
- Memory wait and timeout: WAIT_MAX=8, hold mem_ready=0 for 8 cycles with PCSrcE=1 → all four stalls=1, flushes=0, err_timeout=1 after the 8th edge. Then mem_ready=1 → err_timeout stays 1 until cnt_clr=1, then 0 at the next edge.
- No-forward mode: FWD_EN=0, regwriteW=1, RdW=3, Rs1D=3 → stallF=stallD=flushE=1, forwardAE=00.
- Saturation and reset: CNTW=4, hold haz 20 cycles → stall_cnt=15. Assert rst_n=0 between edges → stall_cnt=0 and state=00 immediately.
